// File: rtl/voice_scheduler_pkg.sv
// Shared widths and FSM encoding for the voice scheduler and its voice slots.
package voice_scheduler_pkg;

    localparam int NUM_VOICES     = 3;
    localparam int NOTE_WIDTH     = 6;
    localparam int DURATION_WIDTH = 6;
    localparam int VOICE_IDX_W    = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/voice_scheduler_voice_slot.sv
// One voice: note register, remaining-beat count and active flag.
module voice_slot
    import voice_scheduler_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [NOTE_WIDTH-1:0]     load_note,
    input  logic [DURATION_WIDTH-1:0] load_dur,
    input  logic                      tick,
    output logic [NOTE_WIDTH-1:0]     note,
    output logic [DURATION_WIDTH-1:0] count,
    output logic                      active
);

    // A load on the same edge as a tick wins; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            note   <= '0;
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            note   <= load_note;
            count  <= load_dur;
            active <= 1'b1;
        end else if (tick && active && (count != '0)) begin
            count <= count - 1'b1;
            if (count == DURATION_WIDTH'(1))
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Three-voice note scheduler: paces notes from the song reader and allocates voices.
// Build option: define VOICE_STEAL_EN to steal the shortest-remaining voice when all are busy.
module voice_scheduler
    import voice_scheduler_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               play,
    input  logic                               beat,
    input  logic                               new_note,
    input  logic [NOTE_WIDTH-1:0]              note,
    input  logic [DURATION_WIDTH-1:0]          duration,
    input  logic                               advance,
    output logic                               note_done,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0]   voice_note,
    output logic [NUM_VOICES-1:0]              voice_load,
    output logic [NUM_VOICES-1:0]              voice_active,
    output logic                               overrun
);

`ifdef VOICE_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    state_t                      state;
    state_t                      state_next;
    logic [NOTE_WIDTH-1:0]       note_r;
    logic [DURATION_WIDTH-1:0]   dur_r;
    logic                        adv_r;
    logic [DURATION_WIDTH-1:0]   pace;
    logic                        tick;
    logic [NUM_VOICES-1:0]       load_vec;
    logic                        found;
    logic [VOICE_IDX_W-1:0]      victim;
    logic [DURATION_WIDTH-1:0]   voice_count [NUM_VOICES];

    assign tick = beat & play;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (new_note) state_next = ALLOC;
            ALLOC: state_next = (adv_r || (dur_r == '0)) ? DONE : HOLD;
            HOLD:  if (tick && (pace == DURATION_WIDTH'(1))) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Voice selection sees the slot counts as they stood before this cycle's beat.
    always_comb begin
        note_done = (state == DONE);
        load_vec  = '0;
        found     = 1'b0;
        victim    = '0;
        if ((state == ALLOC) && (note_r != '0) && (dur_r != '0)) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (!voice_active[i] && !found) begin
                    load_vec[i] = 1'b1;
                    found       = 1'b1;
                end
            end
            if (!found && STEAL_EN) begin
                for (int i = 1; i < NUM_VOICES; i++) begin
                    if (voice_count[i] < voice_count[victim])
                        victim = VOICE_IDX_W'(i);
                end
                load_vec[victim] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            note_r     <= '0;
            dur_r      <= '0;
            adv_r      <= 1'b0;
            pace       <= '0;
            overrun    <= 1'b0;
            voice_load <= '0;
        end else begin
            voice_load <= load_vec;
            if ((state == IDLE) && new_note) begin
                note_r <= note;
                dur_r  <= duration;
                adv_r  <= advance;
            end
            if ((state != IDLE) && new_note)
                overrun <= 1'b1;
            if (state == ALLOC)
                pace <= dur_r;
            else if ((state == HOLD) && tick && (pace != '0))
                pace <= pace - 1'b1;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_slot u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load_vec[v]),
            .load_note (note_r),
            .load_dur  (dur_r),
            .tick      (tick),
            .note      (voice_note[v*NOTE_WIDTH +: NOTE_WIDTH]),
            .count     (voice_count[v]),
            .active    (voice_active[v])
        );
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: directed scenarios plus randomized traffic
// checked against a behavioural model. Honours VOICE_STEAL_EN like the design.
module tb_voice_scheduler;
    import voice_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b1;
    logic        beat = 1'b0;
    logic        new_note = 1'b0;
    logic [5:0]  note = '0;
    logic [5:0]  duration = '0;
    logic        advance = 1'b0;
    logic        note_done;
    logic [17:0] voice_note;
    logic [2:0]  voice_load;
    logic [2:0]  voice_active;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    voice_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .beat         (beat),
        .new_note     (new_note),
        .note         (note),
        .duration     (duration),
        .advance      (advance),
        .note_done    (note_done),
        .voice_note   (voice_note),
        .voice_load   (voice_load),
        .voice_active (voice_active),
        .overrun      (overrun)
    );

    // Behavioural model: a request is accepted when the block is not busy, allocated one
    // cycle later, then either finishes at once or waits out its beats; done lasts a cycle.
    int         m_cnt [3];
    bit         m_act [3];
    logic [5:0] m_code [3];
    logic [2:0] m_load;
    bit         m_done, m_ovr, m_busy, m_pending, m_holding;
    int         m_left;
    logic [5:0] p_note;
    int         p_dur;
    bit         p_adv;

    always @(posedge clk) begin
        bit       t;
        bit       was_busy;
        int       victim;
        bit [2:0] loaded;
        t = beat && play;
        loaded = '0;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_act[i] = 0; m_code[i] = '0;
            end
            m_load = '0; m_done = 0; m_ovr = 0; m_busy = 0;
            m_pending = 0; m_holding = 0; m_left = 0;
        end else begin
            was_busy = m_busy;
            if (m_pending) begin
                m_pending = 0;
                victim = -1;
                if (p_note != 0 && p_dur != 0) begin
                    for (int i = 0; i < 3; i++)
                        if (!m_act[i] && victim < 0) victim = i;
`ifdef VOICE_STEAL_EN
                    if (victim < 0) begin
                        victim = 0;
                        for (int i = 1; i < 3; i++)
                            if (m_cnt[i] < m_cnt[victim]) victim = i;
                    end
`endif
                end
                if (victim >= 0) loaded[victim] = 1'b1;
                if (p_adv || p_dur == 0) m_done = 1;
                else begin m_holding = 1; m_left = p_dur; end
            end else if (m_done) begin
                m_done = 0; m_busy = 0;
            end else if (m_holding && t) begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_holding = 0; m_done = 1; end
            end
            for (int i = 0; i < 3; i++) begin
                if (loaded[i]) begin
                    m_code[i] = p_note; m_cnt[i] = p_dur; m_act[i] = 1;
                end else if (t && m_act[i]) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) m_act[i] = 0;
                end
            end
            m_load = loaded;
            if (new_note) begin
                if (was_busy) m_ovr = 1;
                else begin
                    m_busy = 1; m_pending = 1;
                    p_note = note; p_dur = int'(duration); p_adv = advance;
                end
            end
        end
    end

    // One clock: inputs held across the rising edge, outputs settled at the next falling edge.
    task automatic cyc(input bit b);
        beat = b;
        @(negedge clk);
        beat = 1'b0;
        new_note = 1'b0;
    endtask

    task automatic issue(input logic [5:0] n, input logic [5:0] d, input bit a);
        note = n; duration = d; advance = a; new_note = 1'b1;
        cyc(1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(0); cyc(0);
        reset = 1'b0;
        checks++; if (note_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_note_done got=%b exp=0", note_done); end
        checks++; if (voice_active !== 3'b000) begin failures++; $display("[TB] FAIL reset_active got=%b exp=000", voice_active); end
        checks++; if (voice_note !== 18'h0) begin failures++; $display("[TB] FAIL reset_voice_note got=%h exp=0", voice_note); end
        checks++; if (voice_load !== 3'b000) begin failures++; $display("[TB] FAIL reset_load got=%b exp=000", voice_load); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_single_note();
        int early = 0;
        issue(6'd12, 6'd3, 1'b0);
        cyc(0);
        checks++; if (voice_load !== 3'b001) begin failures++; $display("[TB] FAIL single_load got=%b exp=001", voice_load); end
        checks++; if (voice_note[5:0] !== 6'd12) begin failures++; $display("[TB] FAIL single_code got=%0d exp=12", voice_note[5:0]); end
        checks++; if (voice_active !== 3'b001) begin failures++; $display("[TB] FAIL single_active got=%b exp=001", voice_active); end
        for (int k = 0; k < 3; k++) begin
            repeat (3) begin cyc(0); if (note_done) early++; end
            cyc(1);
            if (k < 2 && note_done) early++;
        end
        checks++; if (note_done !== 1'b1) begin failures++; $display("[TB] FAIL single_done got=%b exp=1", note_done); end
        checks++; if (voice_active[0] !== 1'b0) begin failures++; $display("[TB] FAIL single_release got=%b exp=0", voice_active[0]); end
        checks++; if (early != 0) begin failures++; $display("[TB] FAIL single_early_done got=%0d exp=0", early); end
        cyc(0);
        checks++; if (note_done !== 1'b0) begin failures++; $display("[TB] FAIL single_done_width got=%b exp=0", note_done); end
    endtask

    task automatic test_chord();
        logic [5:0] codes [3];
        int early = 0;
        codes[0] = 6'd5; codes[1] = 6'd9; codes[2] = 6'd14;
        for (int i = 0; i < 3; i++) begin
            issue(codes[i], 6'd4, (i < 2));
            cyc(0);
            checks++; if (voice_load !== 3'(1 << i)) begin failures++; $display("[TB] FAIL chord_load%0d got=%b exp=%b", i, voice_load, 3'(1 << i)); end
            checks++; if (voice_note[i*6 +: 6] !== codes[i]) begin failures++; $display("[TB] FAIL chord_code%0d got=%0d exp=%0d", i, voice_note[i*6 +: 6], codes[i]); end
            if (i < 2) begin
                checks++; if (note_done !== 1'b1) begin failures++; $display("[TB] FAIL chord_done%0d got=%b exp=1", i, note_done); end
                cyc(0);
            end
        end
        for (int b = 0; b < 4; b++) begin
            cyc(0); if (note_done) early++;
            cyc(1); if (b < 3 && note_done) early++;
        end
        checks++; if (note_done !== 1'b1) begin failures++; $display("[TB] FAIL chord_last_done got=%b exp=1", note_done); end
        checks++; if (voice_active !== 3'b000) begin failures++; $display("[TB] FAIL chord_release got=%b exp=000", voice_active); end
        checks++; if (early != 0) begin failures++; $display("[TB] FAIL chord_early_done got=%0d exp=0", early); end
        cyc(0);
    endtask

    task automatic test_steal();
        logic [2:0] exp_load;
        logic [2:0] exp_act5;
        logic [5:0] exp_code1;
`ifdef VOICE_STEAL_EN
        exp_load = 3'b010; exp_act5 = 3'b010; exp_code1 = 6'd20;
`else
        exp_load = 3'b000; exp_act5 = 3'b000; exp_code1 = 6'd2;
`endif
        issue(6'd1, 6'd5, 1'b1); cyc(0); cyc(0);
        issue(6'd2, 6'd2, 1'b1); cyc(0); cyc(0);
        issue(6'd3, 6'd4, 1'b1); cyc(0); cyc(0);
        issue(6'd20, 6'd6, 1'b1); cyc(0);
        checks++; if (voice_load !== exp_load) begin failures++; $display("[TB] FAIL steal_load got=%b exp=%b", voice_load, exp_load); end
        checks++; if (voice_note[11:6] !== exp_code1) begin failures++; $display("[TB] FAIL steal_code got=%0d exp=%0d", voice_note[11:6], exp_code1); end
        cyc(0);
        for (int b = 1; b <= 6; b++) begin
            cyc(1);
            if (b == 5) begin
                checks++; if (voice_active !== exp_act5) begin failures++; $display("[TB] FAIL steal_count got=%b exp=%b", voice_active, exp_act5); end
            end
        end
        checks++; if (voice_active !== 3'b000) begin failures++; $display("[TB] FAIL steal_release got=%b exp=000", voice_active); end
    endtask

    task automatic test_pause();
        int bad = 0;
        issue(6'd7, 6'd4, 1'b0); cyc(0);
        cyc(1); cyc(1);
        play = 1'b0;
        repeat (10) begin
            cyc(1);
            if (note_done !== 1'b0 || voice_active !== 3'b001) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL pause_hold got=%0d exp=0", bad); end
        play = 1'b1;
        cyc(1);
        checks++; if (note_done !== 1'b0) begin failures++; $display("[TB] FAIL pause_resume1 got=%b exp=0", note_done); end
        cyc(1);
        checks++; if (note_done !== 1'b1) begin failures++; $display("[TB] FAIL pause_resume2 got=%b exp=1", note_done); end
        checks++; if (voice_active !== 3'b000) begin failures++; $display("[TB] FAIL pause_release got=%b exp=000", voice_active); end
        cyc(0);
    endtask

    task automatic test_rest();
        issue(6'd0, 6'd2, 1'b0); cyc(0);
        checks++; if (voice_load !== 3'b000) begin failures++; $display("[TB] FAIL rest_load got=%b exp=000", voice_load); end
        cyc(1);
        checks++; if (note_done !== 1'b0) begin failures++; $display("[TB] FAIL rest_early got=%b exp=0", note_done); end
        cyc(1);
        checks++; if (note_done !== 1'b1) begin failures++; $display("[TB] FAIL rest_done got=%b exp=1", note_done); end
        cyc(0);
    endtask

    task automatic test_overrun_reset();
        int seen = 0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL overrun_pre got=%b exp=0", overrun); end
        issue(6'd3, 6'd5, 1'b0); cyc(0);
        issue(6'd4, 6'd1, 1'b0);
        checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_set got=%b exp=1", overrun); end
        cyc(1);
        reset = 1'b1; cyc(0); reset = 1'b0;
        checks++; if ({note_done, voice_active, voice_load, overrun} !== 8'h00 || voice_note !== 18'h0)
            begin failures++; $display("[TB] FAIL hold_reset got=%b/%b/%b/%b/%h exp=all zero", note_done, voice_active, voice_load, overrun, voice_note); end
        repeat (6) begin cyc(1); if (note_done) seen++; end
        checks++; if (seen != 0) begin failures++; $display("[TB] FAIL hold_reset_done got=%0d exp=0", seen); end
    endtask

    task automatic test_random();
        logic [17:0] exp_notes;
        logic [2:0]  exp_act;
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            play     = ($urandom_range(0, 4) != 0);
            new_note = ($urandom_range(0, 3) == 0);
            note     = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            duration = 6'($urandom_range(0, 6));
            advance  = ($urandom_range(0, 2) == 0);
            cyc($urandom_range(0, 2) == 0);
            reset = 1'b0;
            exp_notes = {m_code[2], m_code[1], m_code[0]};
            exp_act   = {m_act[2], m_act[1], m_act[0]};
            checks++; if (note_done !== m_done) begin failures++; $display("[TB] FAIL rnd_done cyc=%0d got=%b exp=%b", c, note_done, m_done); end
            checks++; if (voice_load !== m_load) begin failures++; $display("[TB] FAIL rnd_load cyc=%0d got=%b exp=%b", c, voice_load, m_load); end
            checks++; if (voice_active !== exp_act) begin failures++; $display("[TB] FAIL rnd_active cyc=%0d got=%b exp=%b", c, voice_active, exp_act); end
            checks++; if (voice_note !== exp_notes) begin failures++; $display("[TB] FAIL rnd_notes cyc=%0d got=%h exp=%h", c, voice_note, exp_notes); end
            checks++; if (overrun !== m_ovr) begin failures++; $display("[TB] FAIL rnd_overrun cyc=%0d got=%b exp=%b", c, overrun, m_ovr); end
        end
        play = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_note();
        test_chord();
        test_steal();
        test_pause();
        test_rest();
        test_overrun_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameters: none; all widths come from the shared package constants (REQ-029).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 play  input  1  run enable; 0 freezes every countdown.
REQ-005 beat  input  1  one-cycle duration tick; one beat equals one duration unit.
REQ-006 new_note  input  1  one-cycle pulse from the song reader; note, duration and advance are valid in that cycle.
REQ-007 note  input  6  note code; 0 means rest.
REQ-008 duration  input  6  note length in beats.
REQ-009 advance  input  1  1 means chord member: the reader moves on immediately, without waiting out the duration.
REQ-010 note_done  output  1  one-cycle pulse; tells the reader to fetch the next note.
REQ-011 voice_note  output  18  three 6-bit note codes; voice i is in bits [6i+5:6i].
REQ-012 voice_load  output  3  one-cycle pulse per voice when a new note is written to it.
REQ-013 voice_active  output  3  voice is sounding.
REQ-014 overrun  output  1  sticky; new_note arrived while the block was not IDLE.

Function
REQ-015 FSM states: IDLE, ALLOC, HOLD, DONE.
- IDLE -> ALLOC on new_note; note, duration and advance are registered.
- ALLOC -> DONE if advance=1 or duration=0; otherwise -> HOLD.
- HOLD -> DONE on the beat that takes the pace counter from 1 to 0.
- DONE -> IDLE unconditionally.
REQ-016 note_done is high only in the DONE state, giving exactly one cycle per accepted new_note.
REQ-017 ALLOC loads the pace counter with duration. In HOLD, the counter decrements on each beat with play=1.
REQ-018 In ALLOC, a note with note≠0 and duration≠0 is written to the lowest-index idle voice.
- The voice's count is set to duration, active is set to 1, and its voice_load bit pulses in the following cycle.
- A note with note=0 or duration=0 is never written to a voice; it affects pacing only.
REQ-019 Voice countdown: on each beat with play=1, every active voice decrements its count; a voice at count 1 clears active on that same edge.
REQ-020 If a voice is loaded and a beat occurs in the same cycle, the load wins and no decrement happens for that voice.
REQ-021 Allocation and stealing decisions use the count and active values from before that cycle's beat.
REQ-022 With play=0, beats are ignored: the FSM, pace counter and voice counts all hold, and voice_active stays unchanged.
REQ-023 A new_note pulse in any state other than IDLE is dropped and sets overrun; the FSM is unaffected.
REQ-024 Arithmetic: all counts are 6-bit unsigned, and no counter decrements below 0.
REQ-025 voice_note holds the last code loaded into each voice, including after that voice goes inactive.

Reset
REQ-026 When reset is asserted, on the next edge: state=IDLE; all counts=0; voice_active=0; voice_note=0; voice_load=0; note_done=0; overrun=0.
REQ-027 Reset asserted mid-HOLD or mid-ALLOC discards the pending note, and no note_done is emitted.

Configuration
REQ-028 Macro VOICE_STEAL_EN controls what happens when all three voices are active at ALLOC.
- Defined: the note overwrites the active voice with the smallest remaining count; ties go to the lowest index.
- Undefined: the note is not written anywhere.
- In both cases pacing and note_done proceed per REQ-015.

Structure
REQ-029 The shared package defines:
- NUM_VOICES=3, NOTE_WIDTH=6, DURATION_WIDTH=6;
- the FSM state encodings (2-bit).
REQ-030 Sub-module voice_slot holds one voice's note register, count and active bit, with ports: load, load_note, load_dur, tick, note, count, active. It is instantiated NUM_VOICES times.
REQ-031 All state is held in dffr-style synchronous-reset registers.

Verification
REQ-032 Single note: note=12, duration=3, advance=0, all voices idle, beats every 4 cycles.
- Voice 0 loads 12 and voice_load=001.
- note_done pulses on the cycle after the third beat.
- voice_active[0] clears on that third beat.
REQ-033 Chord: three new_notes with advance=1,1,0, codes 5/9/14, duration 4 each.
- Voices 0/1/2 are loaded in that order.
- The first two note_done pulses come 2 cycles after each new_note.
- The third note_done comes after 4 beats.
REQ-034 Steal, VOICE_STEAL_EN defined: voices at counts 5/2/4, new note=20, duration=6.
- Voice 1 is overwritten and its count becomes 6.
- With the macro undefined, no voice_load pulses.
REQ-035 Pause: play=0 during HOLD with 2 beats remaining, while 10 beats are applied.
- Counts are unchanged and no note_done is emitted.
- After play=1, note_done follows 2 beats later.
REQ-036 Edge cases:
- A rest (note=0, duration=2) gives no voice_load, with note_done after 2 beats.
- new_note during HOLD sets overrun=1.
- Reset in HOLD clears all outputs and no note_done follows.
